clkdiv_prog: RTL and testbench

- Runtime-programmable integer clock divider. Successor to the fixed-DIVISOR divider.
- Adds:
  - divisor loading through a valid/ready handshake;
  - glitch-free divisor changes that take effect only at a period boundary;
  - a graceful enable/stop sequence;
  - a single-cycle tick strobe;
  - illegal-divisor detection.
- Sits between the board clock and slow peripherals (LED scan, UART baud generation, debouncers).

---
 rtl/clkdiv_pkg.sv | 11 +
 rtl/clkdiv_cfg_if.sv | 41 ++++
 rtl/clkdiv_prog.sv | 100 ++++++++++
 tb/tb_clkdiv_prog.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/clkdiv_pkg.sv
// clkdiv_pkg: shared FSM state type, constants and the ceil(N/2) helper
// for the programmable clock divider.
package clkdiv_pkg;
   typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;
   localparam int MAX_WIDTH = 32;
   localparam logic [MAX_WIDTH-1:0] DIV_ZERO = '0;
   // (N>>1)+N[0] never overflows, unlike (N+1)>>1 at the top of the range
   function automatic logic [MAX_WIDTH-1:0] half_ceil(input logic [MAX_WIDTH-1:0] n);
      return (n >> 1) + {{(MAX_WIDTH-1){1'b0}}, n[0]};
   endfunction
endpackage

// File: rtl/clkdiv_cfg_if.sv
// clkdiv_cfg_if: divisor valid/ready intake; holds one pending divisor until the
// core applies it, discards zero divisors and latches a sticky cfg_err.
module clkdiv_cfg_if
   import clkdiv_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clock_in,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] div_in,
   input  logic             div_valid,
   input  logic             apply,
   output logic [WIDTH-1:0] pend_div,
   output logic             pend_valid,
   output logic             div_ready,
   output logic             cfg_err
);
   logic xfer;
   logic zero;
   assign xfer = div_valid & div_ready;
   assign zero = div_in == WIDTH'(DIV_ZERO);
   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         pend_div   <= '0;
         pend_valid <= 1'b0;
         div_ready  <= 1'b1;
         cfg_err    <= 1'b0;
      end else begin
         if (xfer && !zero) begin
            pend_div   <= div_in;
            pend_valid <= 1'b1;
            div_ready  <= 1'b0;
         end else if (apply) begin
            pend_valid <= 1'b0;
            div_ready  <= 1'b1;
         end
         if (xfer && zero)
            cfg_err <= 1'b1;
      end
   end
endmodule

// File: rtl/clkdiv_prog.sv
// clkdiv_prog: runtime-programmable integer clock divider with graceful stop.
// Define CLKDIV_DUTY50_EN for exact 50% duty on odd divisors (adds a negedge flop).
module clkdiv_prog
   import clkdiv_pkg::*;
#(
   parameter int               WIDTH       = 16,
   parameter logic [WIDTH-1:0] DEFAULT_DIV = WIDTH'(2)
) (
   input  logic             clock_in,
   input  logic             reset_n,
   input  logic             enable,
   input  logic [WIDTH-1:0] div_in,
   input  logic             div_valid,
   output logic             div_ready,
   output logic             clock_out,
   output logic             tick_out,
   output logic             busy,
   output logic             cfg_err
);
   state_t               state, state_n;
   logic [WIDTH-1:0]     cnt, cnt_n, cur_div, cur_div_n, pend_div;
   logic                 pend_valid, apply, wrap, hi, hi_n, tick_n;
   logic [MAX_WIDTH-1:0] thresh;

   clkdiv_cfg_if #(.WIDTH(WIDTH)) u_cfg (
      .clock_in   (clock_in),
      .reset_n    (reset_n),
      .div_in     (div_in),
      .div_valid  (div_valid),
      .apply      (apply),
      .pend_div   (pend_div),
      .pend_valid (pend_valid),
      .div_ready  (div_ready),
      .cfg_err    (cfg_err)
   );

   // Outputs are registered from next-state values so they line up with cnt.
   always_comb begin
      wrap    = cnt == cur_div - WIDTH'(1);
      state_n = state;
      cnt_n   = cnt;
      apply   = 1'b0;
      case (state)
         IDLE: begin
            apply = pend_valid;
            if (enable) state_n = RUN;
         end
         RUN: begin
            cnt_n = wrap ? '0 : cnt + WIDTH'(1);
            apply = wrap & pend_valid;
            if (!enable) state_n = wrap ? IDLE : STOPPING;
         end
         STOPPING: begin
            cnt_n   = wrap ? '0 : cnt + WIDTH'(1);
            apply   = wrap & pend_valid;
            state_n = enable ? RUN : wrap ? IDLE : STOPPING;
         end
         default: state_n = IDLE;
      endcase
      cur_div_n = apply ? pend_div : cur_div;
`ifdef CLKDIV_DUTY50_EN
      thresh = (cur_div_n[0] && cur_div_n != WIDTH'(1)) ? MAX_WIDTH'(cur_div_n >> 1)
                                                       : half_ceil(MAX_WIDTH'(cur_div_n));
`else
      thresh = half_ceil(MAX_WIDTH'(cur_div_n));
`endif
      hi_n   = state_n != IDLE && MAX_WIDTH'(cnt_n) < thresh;
      tick_n = state_n == RUN && cnt_n == '0;
   end

   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         cnt      <= '0;
         cur_div  <= DEFAULT_DIV;
         hi       <= 1'b0;
         tick_out <= 1'b0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         cur_div  <= cur_div_n;
         hi       <= hi_n;
         tick_out <= tick_n;
      end
   end

   assign busy = state != IDLE;

`ifdef CLKDIV_DUTY50_EN
   // Half-cycle extension of the high phase for odd divisors above 1.
   logic hi_dly;
   always_ff @(negedge clock_in or negedge reset_n) begin
      if (!reset_n) hi_dly <= 1'b0;
      else          hi_dly <= hi & cur_div[0] & (cur_div != WIDTH'(1));
   end
   assign clock_out = hi | hi_dly;
`else
   assign clock_out = hi;
`endif
endmodule

// File: tb/tb_clkdiv_prog.sv
// tb_clkdiv_prog: directed self-checking bench for clkdiv_prog (default build).
module tb_clkdiv_prog;
   logic        clock_in = 1'b0;
   logic        reset_n = 1'b0;
   logic        enable = 1'b0;
   logic        div_valid = 1'b0;
   logic [15:0] div_in = '0;
   logic        div_ready, clock_out, tick_out, busy, cfg_err;
   int          passed = 0;
   int          total = 0;

   clkdiv_prog #(.WIDTH(16), .DEFAULT_DIV(16'd2)) dut (
      .clock_in  (clock_in),
      .reset_n   (reset_n),
      .enable    (enable),
      .div_in    (div_in),
      .div_valid (div_valid),
      .div_ready (div_ready),
      .clock_out (clock_out),
      .tick_out  (tick_out),
      .busy      (busy),
      .cfg_err   (cfg_err)
   );

   always #5 clock_in = ~clock_in;

   task automatic load(input logic [15:0] d);
      div_in = d;
      div_valid = 1'b1;
      @(negedge clock_in);
      div_valid = 1'b0;
      @(negedge clock_in);
   endtask

   task automatic test_reset();
      @(negedge clock_in);
      total++;
      if ({clock_out, tick_out, busy, div_ready, cfg_err} !== 5'b00010)
         $display("FAIL reset_in: got %b want 00010", {clock_out, tick_out, busy, div_ready, cfg_err});
      else passed++;
      reset_n = 1'b1;
      @(negedge clock_in);
      total++;
      if ({clock_out, tick_out, busy, div_ready, cfg_err} !== 5'b00010)
         $display("FAIL reset_out: got %b want 00010", {clock_out, tick_out, busy, div_ready, cfg_err});
      else passed++;
   endtask

   task automatic test_div2();
      logic [2:0] e;
      enable = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clock_in);
         e = (i % 2 == 0) ? 3'b111 : 3'b001;
         total++;
         if ({clock_out, tick_out, busy} !== e)
            $display("FAIL div2[%0d]: got %b want %b", i, {clock_out, tick_out, busy}, e);
         else passed++;
      end
      enable = 1'b0;
      @(negedge clock_in);
      total++;
      if ({clock_out, tick_out, busy} !== 3'b000)
         $display("FAIL div2_stop: got %b want 000", {clock_out, tick_out, busy});
      else passed++;
   endtask

   task automatic test_load5();
      logic [2:0] e;
      div_in = 16'd5;
      div_valid = 1'b1;
      @(negedge clock_in);
      total++;
      if (div_ready !== 1'b0) $display("FAIL load5_ready_low: got %b want 0", div_ready);
      else passed++;
      div_valid = 1'b0;
      @(negedge clock_in);
      total++;
      if (div_ready !== 1'b1) $display("FAIL load5_ready_back: got %b want 1", div_ready);
      else passed++;
      enable = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clock_in);
         e = {1'(i % 5 < 3), 1'(i % 5 == 0), 1'b1};
         total++;
         if ({clock_out, tick_out, busy} !== e)
            $display("FAIL div5[%0d]: got %b want %b", i, {clock_out, tick_out, busy}, e);
         else passed++;
      end
      enable = 1'b0;
      @(negedge clock_in);
      total++;
      if (busy !== 1'b0) $display("FAIL div5_stop: busy got %b want 0", busy);
      else passed++;
   endtask

   task automatic test_change();
      logic [11:0] ce, te, re;
      logic [2:0]  e;
      ce = 12'b1000_1111_0011;
      te = 12'b1000_0001_0001;
      re = 12'b1111_1111_0011;
      load(16'd4);
      enable = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clock_in);
         e = {ce[i], te[i], re[i]};
         total++;
         if ({clock_out, tick_out, div_ready} !== e)
            $display("FAIL change[%0d]: clk/tick/ready got %b want %b", i, {clock_out, tick_out, div_ready}, e);
         else passed++;
         if (i == 1) begin
            div_in = 16'd7;
            div_valid = 1'b1;
         end
         if (i == 2) div_valid = 1'b0;
      end
      enable = 1'b0;
      for (int k = 0; k < 20 && busy; k++) @(negedge clock_in);
      total++;
      if ({busy, clock_out} !== 2'b00)
         $display("FAIL change_stop: busy/clk got %b want 00", {busy, clock_out});
      else passed++;
   endtask

   task automatic test_stop();
      logic [6:0] ce, te, be;
      logic [2:0] e;
      int         c;
      ce = 7'b0000111;
      te = 7'b0000001;
      be = 7'b0111111;
      load(16'd6);
      enable = 1'b1;
      for (int i = 0; i < 7; i++) begin
         @(negedge clock_in);
         e = {ce[i], te[i], be[i]};
         total++;
         if ({clock_out, tick_out, busy} !== e)
            $display("FAIL stop[%0d]: got %b want %b", i, {clock_out, tick_out, busy}, e);
         else passed++;
         if (i == 2) enable = 1'b0;
      end
      enable = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clock_in);
         c = i % 6;
         e = {1'(c < 3), 1'(c == 0), 1'b1};
         total++;
         if ({clock_out, tick_out, busy} !== e)
            $display("FAIL resume[%0d]: got %b want %b", i, {clock_out, tick_out, busy}, e);
         else passed++;
         if (i == 2) enable = 1'b0;
         if (i == 4) enable = 1'b1;
      end
      enable = 1'b0;
      @(negedge clock_in);
      total++;
      if ({clock_out, busy} !== 2'b00)
         $display("FAIL resume_stop: clk/busy got %b want 00", {clock_out, busy});
      else passed++;
   endtask

   task automatic test_zero();
      logic [2:0] e;
      div_in = 16'd0;
      div_valid = 1'b1;
      @(negedge clock_in);
      total++;
      if ({cfg_err, div_ready} !== 2'b11)
         $display("FAIL zero_err: err/ready got %b want 11", {cfg_err, div_ready});
      else passed++;
      div_valid = 1'b0;
      @(negedge clock_in);
      total++;
      if ({cfg_err, div_ready} !== 2'b11)
         $display("FAIL zero_sticky: err/ready got %b want 11", {cfg_err, div_ready});
      else passed++;
      enable = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clock_in);
         e = {1'(i < 3), 1'(i == 0), 1'b1};
         total++;
         if ({clock_out, tick_out, busy} !== e)
            $display("FAIL zero_keep6[%0d]: got %b want %b", i, {clock_out, tick_out, busy}, e);
         else passed++;
      end
      enable = 1'b0;
      @(negedge clock_in);
      load(16'd1);
      enable = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock_in);
         total++;
         if ({clock_out, tick_out, busy} !== 3'b111)
            $display("FAIL div1[%0d]: got %b want 111", i, {clock_out, tick_out, busy});
         else passed++;
      end
      enable = 1'b0;
      @(negedge clock_in);
      total++;
      if ({clock_out, busy, cfg_err} !== 3'b001)
         $display("FAIL div1_stop: clk/busy/err got %b want 001", {clock_out, busy, cfg_err});
      else passed++;
   endtask

   task automatic test_async_reset();
      logic [2:0] e;
      load(16'd9);
      enable = 1'b1;
      @(negedge clock_in);
      @(negedge clock_in);
      div_in = 16'd3;
      div_valid = 1'b1;
      @(negedge clock_in);
      div_valid = 1'b0;
      total++;
      if ({clock_out, busy, div_ready, cfg_err} !== 4'b1101)
         $display("FAIL pre_reset: clk/busy/ready/err got %b want 1101", {clock_out, busy, div_ready, cfg_err});
      else passed++;
      #2 reset_n = 1'b0;
      #1;
      total++;
      if ({clock_out, tick_out, busy, div_ready, cfg_err} !== 5'b00010)
         $display("FAIL async_reset: got %b want 00010", {clock_out, tick_out, busy, div_ready, cfg_err});
      else passed++;
      @(negedge clock_in);
      reset_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock_in);
         e = (i % 2 == 0) ? 3'b111 : 3'b001;
         total++;
         if ({clock_out, tick_out, busy} !== e)
            $display("FAIL post_reset_div2[%0d]: got %b want %b", i, {clock_out, tick_out, busy}, e);
         else passed++;
      end
      enable = 1'b0;
   endtask

   initial begin
      test_reset();
      test_div2();
      test_load5();
      test_change();
      test_stop();
      test_zero();
      test_async_reset();
      @(negedge clock_in);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
